// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg: shared types, constants and address decode for bus_responder | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] DI_UNMAPPED = 8'hFF;

  function automatic logic ext_hit(input logic [15:0] ab,
                                   input logic [15:0] base,
                                   input logic [15:0] mask);
    return (ab & mask) == base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_sp.sv
// ----------------------------------------------------------------------------
// ram_sp: single-port synchronous RAM, registered write-first read | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_sp #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else begin
      rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/bus_responder.sv
// ----------------------------------------------------------------------------
// bus_responder: RAM / external req-ack bridge / unmapped responder | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_AW   = 12,
  parameter logic [15:0] EXT_BASE = 16'hC000,
  parameter logic [15:0] EXT_MASK = 16'hF000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic        RDY,
  output logic [7:0]  DI,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_we_q, ext_we_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  di_q, di_d;
  logic        di_ram_q, di_ram_d;

  logic        ram_hit;
  logic        ext_sel;
  logic        rdy;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  assign ram_hit = (AB >> RAM_AW) == 16'd0;
  assign ext_sel = ext_hit(AB, EXT_BASE, EXT_MASK);
  assign ram_we  = rdy && ram_hit && WE && !RST;

  ram_sp #(
    .AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (AB[RAM_AW-1:0]),
    .wdata (DO),
    .rdata (ram_rdata)
  );

  always_comb begin
    rdy = 1'b1;
    if (!RST) begin
      case (state_q)
        IDLE:    rdy = !ext_sel;
        REQ:     rdy = 1'b0;
        default: rdy = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    cap_d       = cap_q;
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
    di_d        = di_q;
    di_ram_d    = 1'b0;

    // A RAM read is presented straight from the RAM output register for one
    // cycle, then folded into di_q so DI holds while the RAM keeps reading.
    if (di_ram_q) begin
      di_d = ram_rdata;
    end

    case (state_q)
      IDLE: begin
        if (ext_sel) begin
          ext_addr_d  = AB;
          ext_we_d    = WE;
          ext_wdata_d = DO;
          ext_req_d   = 1'b1;
          cnt_d       = 8'(TIMEOUT);
          state_d     = REQ;
        end else if (!WE) begin
          if (ram_hit) begin
            di_ram_d = 1'b1;
          end else begin
            di_d = DI_UNMAPPED;
          end
        end
      end
      REQ: begin
        if (ext_ack) begin
          ext_req_d = 1'b0;
          cap_d     = ext_rdata;
          state_d   = DONE;
        end else if (cnt_q == 8'd0) begin
          ext_req_d = 1'b0;
          cap_d     = DI_UNMAPPED;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        di_d    = cap_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 16'h0000;
      ext_wdata_q <= 8'h00;
      cap_q       <= 8'h00;
      cnt_q       <= 8'h00;
      bus_err_q   <= 1'b0;
      di_q        <= 8'h00;
      di_ram_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
      di_q        <= di_d;
      di_ram_q    <= di_ram_d;
    end
  end

  assign RDY       = rdy;
  assign DI        = di_ram_q ? ram_rdata : di_q;
  assign ext_req   = ext_req_q;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign bus_err   = bus_err_q;

endmodule

`default_nettype wire
